crc8_serial: RTL and testbench

- Bit-serial CRC-8 engine built around the XOR feedback primitive.
- Accepts a byte stream on a valid/ready handshake and folds each byte MSB-first through an LFSR, one bit per clock.
- Presents the final CRC on an output handshake when the byte flagged last has been absorbed.
- Sits upstream of framing/transmit logic, and downstream of it as a receive checker: a good frame with its CRC appended yields 0x00.

---
 rtl/crc8_serial_if.sv | 22 ++
 rtl/crc8_serial.sv | 97 +++++++++
 tb/tb_crc8_serial.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/crc8_serial_if.sv
// Byte-in / CRC-out handshake bundle for the bit-serial CRC-8 engine.
// The source/sink side uses master and the engine uses slave.
interface crc8_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       crc_valid;
    logic       crc_ready;
    logic [7:0] crc_out;
    logic       busy;

    modport master (
        output in_valid, in_data, in_last, crc_ready,
        input  in_ready, crc_valid, crc_out, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, crc_ready,
        output in_ready, crc_valid, crc_out, busy
    );
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8: folds each accepted byte MSB-first through the LFSR, one bit per
// clock, and presents the frame CRC on an output handshake after the last byte.
module crc8_serial #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    crc8_serial_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t     state;
    logic [7:0] crc;
    logic [7:0] shreg;
    logic [2:0] cnt;
    logic       last;
    logic       in_ready;
    logic       crc_valid;
    logic       busy;
    logic       fb;

    assign fb            = crc[7] ^ shreg[7];
    assign bus.in_ready  = in_ready;
    assign bus.crc_valid = crc_valid;
    assign bus.busy      = busy;
    assign bus.crc_out   = crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            crc       <= INIT;
            shreg     <= 8'h00;
            cnt       <= 3'd0;
            last      <= 1'b0;
            in_ready  <= 1'b1;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            // Abort wins over any handshake in the same cycle.
            state     <= IDLE;
            crc       <= INIT;
            shreg     <= 8'h00;
            cnt       <= 3'd0;
            last      <= 1'b0;
            in_ready  <= 1'b1;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        shreg    <= bus.in_data;
                        last     <= bus.in_last;
                        cnt      <= 3'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc   <= {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
                    shreg <= {shreg[6:0], 1'b0};
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (last) begin
                            crc_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            // Mid-frame byte: crc carries over into the next byte.
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (bus.crc_ready) begin
                        crc       <= INIT;
                        last      <= 1'b0;
                        crc_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    crc_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crc8_serial.sv
// Directed bench for crc8_serial: expected CRCs are queued as frames are driven
// and popped when the engine presents crc_valid.
module tb_crc8_serial;
    logic clk;
    logic rst_n;
    logic clr;
    int   cyc;
    int   n_chk;
    int   n_fail;
    logic [7:0] exp_q[$];

    crc8_serial_if bus ();

    crc8_serial #(.POLY(8'h07), .INIT(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic l, output int t);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 32'd1);
        @(negedge clk);
        t = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic get_crc(input int hold);
        int n;
        logic [7:0] e;
        logic stable;
        n = 0;
        while (!bus.crc_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("crc_valid_timeout", 32'(n < 100), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("crc_out", {24'd0, bus.crc_out}, {24'd0, e});
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!(bus.crc_valid === 1'b1 && bus.crc_out === e && bus.in_ready === 1'b0))
                    stable = 1'b0;
            end
            chk("backpressure_stable", {31'd0, stable}, 32'd1);
        end
        bus.crc_ready = 1'b1;
        @(negedge clk);
        bus.crc_ready = 1'b0;
        chk("post_out_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        chk("post_out_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int t;
        int tprev;
        int lowcnt;
        logic seen;
        logic busy_ok;
        logic never_valid;
        logic [7:0] singles [3];
        logic [7:0] single_exp [3];

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        bus.crc_ready = 1'b0;

        // Reset held with random inputs
        repeat (5) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            bus.in_last   = 1'($urandom);
            bus.crc_ready = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_crc_out", {24'd0, bus.crc_out}, 32'h00);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.crc_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single-byte frames with the sink always ready
        singles    = '{8'h01, 8'hFF, 8'h00};
        single_exp = '{8'h07, 8'hF3, 8'h00};
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(single_exp[k]);
            bus.crc_ready = 1'b1;
            send_byte(singles[k], 1'b1, t);
            lowcnt = 1;
            seen = 1'b0;
            busy_ok = 1'b1;
            for (int i = 0; i < 30; i++) begin
                if (bus.in_ready) break;
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                if (bus.crc_valid) begin
                    chk("single_valid_at_8", lowcnt, 32'd9);
                    chk("single_crc", {24'd0, bus.crc_out}, {24'd0, exp_q.pop_front()});
                    seen = 1'b1;
                end
                @(negedge clk);
                lowcnt++;
            end
            bus.crc_ready = 1'b0;
            chk("single_seen", {31'd0, seen}, 32'd1);
            chk("single_ready_low_9", lowcnt - 1, 32'd9);
            chk("single_busy", {31'd0, busy_ok}, 32'd1);
        end

        // "123456789" with in_valid held high between bytes
        exp_q.push_back(8'hF4);
        send_byte(8'h31, 1'b0, tprev);
        for (int b = 8'h32; b <= 8'h39; b++) begin
            send_byte(8'(b), (b == 8'h39), t);
            chk("byte_spacing", t - tprev, 32'd9);
            tprev = t;
        end
        get_crc(0);

        // Frame with its CRC appended checks to zero
        exp_q.push_back(8'h00);
        for (int b = 8'h31; b <= 8'h39; b++) send_byte(8'(b), 1'b0, t);
        send_byte(8'hF4, 1'b1, t);
        get_crc(0);

        // Output backpressure, then a fresh frame must start from INIT
        exp_q.push_back(8'hF4);
        for (int b = 8'h31; b <= 8'h39; b++) send_byte(8'(b), (b == 8'h39), t);
        get_crc(20);
        exp_q.push_back(8'h07);
        send_byte(8'h01, 1'b1, t);
        get_crc(0);

        // Abort mid-byte of 0x35
        for (int b = 8'h31; b <= 8'h35; b++) send_byte(8'(b), 1'b0, t);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("clr_busy", {31'd0, bus.busy}, 32'd0);
        chk("clr_crc_out", {24'd0, bus.crc_out}, 32'h00);
        never_valid = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.crc_valid !== 1'b0) never_valid = 1'b0;
        end
        chk("clr_no_crc_valid", {31'd0, never_valid}, 32'd1);
        exp_q.push_back(8'hF4);
        for (int b = 8'h31; b <= 8'h39; b++) send_byte(8'(b), (b == 8'h39), t);
        get_crc(0);

        // Asynchronous reset while a CRC is pending
        send_byte(8'h01, 1'b1, t);
        lowcnt = 0;
        while (!bus.crc_valid && lowcnt < 100) begin
            @(negedge clk);
            lowcnt++;
        end
        chk("async_reach_out", {31'd0, bus.crc_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        chk("async_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("async_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'hF3);
        send_byte(8'hFF, 1'b1, t);
        get_crc(0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
